hit_resolver: RTL and testbench
===============================

# hit_resolver

Registered hit-resolution block that consumes both fighters' hitbox/hurtbox descriptors, as produced by each player's box generator, and decides on every game frame whether an attack lands. It enforces one hit per attack-active window, arbitrates same-frame hits (clash or trade), keeps per-player saturating hit counts, and drives a hitstop freeze that the player state machines and the renderer use to pause the game.

## Interface
Parameters:
- HITSTOP_FRAMES, 8: frame ticks of freeze after any hit or clash event; 0 disables hitstop.
- SCORE_W, 4: width of each saturating hit counter.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle game-frame strobe; all evaluation happens on this strobe.
- p1_hitbox_x1/x2/y1/y2, p1_hurtbox_x1/x2/y1/y2  in  10 each  player 1 boxes, unsigned pixels.
- p1_hitbox_active, p1_hurtbox_active  in  1 each  player 1 box valid flags.
- p2_hitbox_x1/x2/y1/y2, p2_hurtbox_x1/x2/y1/y2, p2_hitbox_active, p2_hurtbox_active  in  same as player 1.
- p1_hit  out  1  one-cycle pulse: player 1's attack landed on player 2.
- p2_hit  out  1  one-cycle pulse: player 2's attack landed on player 1.
- clash  out  1  one-cycle pulse: same-frame mutual hit, resolved as a clash.
- freeze  out  1  hitstop active.
- p1_score, p2_score  out  SCORE_W  saturating landed-hit counts.

## Operation
- Overlap test for boxes A and B: the X ranges overlap (A.x1 < B.x2 and B.x1 < A.x2) and the Y ranges overlap by the same strict rule. Edges that only touch do not overlap. Compare as 10-bit unsigned values.
- Raw hit condition for player 1: p1_hitbox_active, p2_hurtbox_active and overlap(p1 hitbox, p2 hurtbox). Player 2 is symmetric.
- Consumed latches c1 and c2:
  - A raw hit counts only while that player's latch is 0.
  - A counted hit sets the latch.
  - A latch clears on a frame_tick in IDLE when the player's hitbox_active is 0.
  - Result: one landed hit per active window.
- States:
  - IDLE: evaluate on each frame_tick. Any counted event emits its pulses. If HITSTOP_FRAMES > 0, load cnt = HITSTOP_FRAMES and go to HITSTOP.
  - HITSTOP: no evaluation and no latch clears. Each frame_tick decrements cnt. The frame_tick that sees cnt == 1 returns to IDLE.
- Single-sided hit: the matching pulse fires and the matching score increments, saturating at 2^SCORE_W−1.
- Both players hit on the same tick: handled by the macro (see Configuration).

## Timing
- All outputs are registered.
- Event pulses and score updates appear the cycle after the clk edge that sampled frame_tick=1, and last exactly one cycle.
- freeze rises in the same cycle as the event pulse. It stays high for exactly HITSTOP_FRAMES frame_ticks and falls the cycle after the last one.
- The first re-evaluation happens on the next frame_tick after freeze falls.
- Box inputs are sampled only on frame_tick edges. Changes between ticks are ignored.
- Reset values: p1_hit=0, p2_hit=0, clash=0, freeze=0, p1_score=0, p2_score=0, c1=c2=0, state=IDLE, cnt=0.
- Reset asserted mid-HITSTOP aborts the freeze and clears everything the next cycle.
- rst has priority over frame_tick.
- With HITSTOP_FRAMES=0, freeze stays 0 and evaluation occurs on every tick.

## Configuration
- HIT_CLASH_EN defined, same-tick mutual hit:
  - clash pulses; p1_hit and p2_hit stay 0.
  - Scores are unchanged.
  - c1 and c2 are both set; hitstop is entered.
- HIT_CLASH_EN undefined, same-tick mutual hit (trade):
  - p1_hit and p2_hit both pulse.
  - Both scores increment.
  - clash is tied to 0.

## Structure
- Shared package footsies_pkg holds the coordinate width (10), the resolver state encoding (IDLE, HITSTOP) and the default HITSTOP_FRAMES.
- Sub-module box_overlap: purely combinational 4-comparator strict-overlap test, instantiated twice (p1 hitbox vs p2 hurtbox, p2 hitbox vs p1 hurtbox).
- Latches, FSM, counter and scores live in hit_resolver.

## Test plan
- **Single hit, freeze length:** p1 hitbox (100,130,34,94) active, p2 hurtbox (120,160,0,128) active, one frame_tick. Expect p1_hit one cycle, p1_score=1, freeze high for 8 ticks, p2_hit=0.
- **Edge touch:** p1 hitbox x2=120, p2 hurtbox x1=120. Expect no pulse and no freeze.
- **Once per window:** overlap held for 20 ticks. Expect exactly one p1_hit; p1_score=1 after freeze ends. Drop hitbox_active for 1 tick, then re-overlap: second p1_hit, p1_score=2.
- **Mutual hit:** both overlapping on the same tick. With HIT_CLASH_EN: clash=1, scores 0/0. Without it: p1_hit=p2_hit=1, scores 1/1.
- **Saturation:** SCORE_W=4, land 17 separate windows. Expect p1_score=15 and holding.
- **Reset mid-hitstop:** assert rst at tick 3 of the freeze. Expect freeze=0 and scores 0 next cycle, and a hit on the following tick is detected normally.

Source files
------------

// File: rtl/footsies_pkg.sv
// Shared types for the fighting-game hit logic: box coordinates, the box
// descriptor and the hit resolver state encoding.
package footsies_pkg;

   localparam int COORD_W            = 10;
   localparam int HITSTOP_FRAMES_DEF = 8;

   typedef logic [COORD_W-1:0] coord_t;

   typedef struct packed {
      coord_t x1;
      coord_t x2;
      coord_t y1;
      coord_t y2;
   } box_t;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      HITSTOP = 1'b1
   } res_state_t;

endpackage

// File: rtl/box_overlap.sv
// Strict rectangle overlap test: boxes whose edges only touch do not overlap.
module box_overlap
   import footsies_pkg::*;
(
   input  box_t a,
   input  box_t b,
   output logic hit
);

   assign hit = (a.x1 < b.x2) && (b.x1 < a.x2) &&
                (a.y1 < b.y2) && (b.y1 < a.y2);

endmodule

// File: rtl/hit_resolver.sv
// Per-frame hit resolution with one-hit-per-window latches, hitstop freeze and
// saturating scores. Define HIT_CLASH_EN to turn same-frame mutual hits into a clash.
module hit_resolver
   import footsies_pkg::*;
#(
   parameter int HITSTOP_FRAMES = HITSTOP_FRAMES_DEF,
   parameter int SCORE_W        = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic [COORD_W-1:0] p1_hitbox_x1,
   input  logic [COORD_W-1:0] p1_hitbox_x2,
   input  logic [COORD_W-1:0] p1_hitbox_y1,
   input  logic [COORD_W-1:0] p1_hitbox_y2,
   input  logic [COORD_W-1:0] p1_hurtbox_x1,
   input  logic [COORD_W-1:0] p1_hurtbox_x2,
   input  logic [COORD_W-1:0] p1_hurtbox_y1,
   input  logic [COORD_W-1:0] p1_hurtbox_y2,
   input  logic               p1_hitbox_active,
   input  logic               p1_hurtbox_active,
   input  logic [COORD_W-1:0] p2_hitbox_x1,
   input  logic [COORD_W-1:0] p2_hitbox_x2,
   input  logic [COORD_W-1:0] p2_hitbox_y1,
   input  logic [COORD_W-1:0] p2_hitbox_y2,
   input  logic [COORD_W-1:0] p2_hurtbox_x1,
   input  logic [COORD_W-1:0] p2_hurtbox_x2,
   input  logic [COORD_W-1:0] p2_hurtbox_y1,
   input  logic [COORD_W-1:0] p2_hurtbox_y2,
   input  logic               p2_hitbox_active,
   input  logic               p2_hurtbox_active,
   output logic               p1_hit,
   output logic               p2_hit,
   output logic               clash,
   output logic               freeze,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score
);

   localparam int CNT_W = (HITSTOP_FRAMES < 2) ? 1 : $clog2(HITSTOP_FRAMES + 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

   box_t p1_hit_box, p1_hurt_box, p2_hit_box, p2_hurt_box;
   logic ovl_1on2, ovl_2on1;
   logic ev1, ev2;

   res_state_t         state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               c1, c2, c1_n, c2_n;
   logic               p1_hit_n, p2_hit_n;
   logic [SCORE_W-1:0] s1_n, s2_n;

   assign p1_hit_box  = '{p1_hitbox_x1,  p1_hitbox_x2,  p1_hitbox_y1,  p1_hitbox_y2};
   assign p1_hurt_box = '{p1_hurtbox_x1, p1_hurtbox_x2, p1_hurtbox_y1, p1_hurtbox_y2};
   assign p2_hit_box  = '{p2_hitbox_x1,  p2_hitbox_x2,  p2_hitbox_y1,  p2_hitbox_y2};
   assign p2_hurt_box = '{p2_hurtbox_x1, p2_hurtbox_x2, p2_hurtbox_y1, p2_hurtbox_y2};

   box_overlap u_ovl_1on2 (.a(p1_hit_box), .b(p2_hurt_box), .hit(ovl_1on2));
   box_overlap u_ovl_2on1 (.a(p2_hit_box), .b(p1_hurt_box), .hit(ovl_2on1));

   // A raw hit only counts while the attacker's window is still unconsumed.
   assign ev1 = p1_hitbox_active && p2_hurtbox_active && ovl_1on2 && !c1;
   assign ev2 = p2_hitbox_active && p1_hurtbox_active && ovl_2on1 && !c2;

`ifdef HIT_CLASH_EN
   logic clash_n;
`endif

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      c1_n     = c1;
      c2_n     = c2;
      p1_hit_n = 1'b0;
      p2_hit_n = 1'b0;
      s1_n     = p1_score;
      s2_n     = p2_score;
`ifdef HIT_CLASH_EN
      clash_n  = 1'b0;
`endif
      if (frame_tick) begin
         case (state)
            IDLE: begin
               if (!p1_hitbox_active) c1_n = 1'b0;
               if (!p2_hitbox_active) c2_n = 1'b0;
               if (ev1) c1_n = 1'b1;
               if (ev2) c2_n = 1'b1;
`ifdef HIT_CLASH_EN
               if (ev1 && ev2) begin
                  clash_n = 1'b1;
               end else begin
                  p1_hit_n = ev1;
                  p2_hit_n = ev2;
               end
`else
               p1_hit_n = ev1;
               p2_hit_n = ev2;
`endif
               if (p1_hit_n && (p1_score != SCORE_MAX)) s1_n = p1_score + SCORE_W'(1);
               if (p2_hit_n && (p2_score != SCORE_MAX)) s2_n = p2_score + SCORE_W'(1);
               if ((ev1 || ev2) && (HITSTOP_FRAMES > 0)) begin
                  state_n = HITSTOP;
                  cnt_n   = CNT_W'(HITSTOP_FRAMES);
               end
            end
            HITSTOP: begin
               if (cnt == CNT_W'(1)) begin
                  state_n = IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt - CNT_W'(1);
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         c1       <= 1'b0;
         c2       <= 1'b0;
         p1_hit   <= 1'b0;
         p2_hit   <= 1'b0;
         p1_score <= '0;
         p2_score <= '0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         c1       <= c1_n;
         c2       <= c2_n;
         p1_hit   <= p1_hit_n;
         p2_hit   <= p2_hit_n;
         p1_score <= s1_n;
         p2_score <= s2_n;
      end
   end

`ifdef HIT_CLASH_EN
   always_ff @(posedge clk) begin
      if (rst) clash <= 1'b0;
      else     clash <= clash_n;
   end
`else
   assign clash = 1'b0;
`endif

   // The state register doubles as the registered freeze output.
   assign freeze = (state == HITSTOP);

endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver: vector table, directed multi-frame
// sequences and randomized frames against a behavioural model.
module tb_hit_resolver;
   import footsies_pkg::*;

   localparam int HS = 8;
   localparam int SW = 4;
   localparam int SMAX = 15;

   typedef struct { int x1; int x2; int y1; int y2; } bx_t;
   typedef struct {
      bx_t a1; bx_t h1; bx_t a2; bx_t h2;
      logic [3:0] act;   // {p1 hitbox, p1 hurtbox, p2 hitbox, p2 hurtbox}
      int ep1; int ep2; int ecl;
   } vec_t;

   logic clk = 1'b0, rst, frame_tick;
   logic [9:0] p1_hitbox_x1, p1_hitbox_x2, p1_hitbox_y1, p1_hitbox_y2;
   logic [9:0] p1_hurtbox_x1, p1_hurtbox_x2, p1_hurtbox_y1, p1_hurtbox_y2;
   logic [9:0] p2_hitbox_x1, p2_hitbox_x2, p2_hitbox_y1, p2_hitbox_y2;
   logic [9:0] p2_hurtbox_x1, p2_hurtbox_x2, p2_hurtbox_y1, p2_hurtbox_y2;
   logic p1_hitbox_active, p1_hurtbox_active, p2_hitbox_active, p2_hurtbox_active;
   logic p1_hit, p2_hit, clash, freeze;
   logic [SW-1:0] p1_score, p2_score;

   int n_chk = 0, n_fail = 0;

   // behavioural model state
   bit m_c1, m_c2;
   int m_frz, m_s1, m_s2, e_p1, e_p2, e_cl;

   always #5 clk = ~clk;

   hit_resolver #(.HITSTOP_FRAMES(HS), .SCORE_W(SW)) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick),
      .p1_hitbox_x1(p1_hitbox_x1), .p1_hitbox_x2(p1_hitbox_x2),
      .p1_hitbox_y1(p1_hitbox_y1), .p1_hitbox_y2(p1_hitbox_y2),
      .p1_hurtbox_x1(p1_hurtbox_x1), .p1_hurtbox_x2(p1_hurtbox_x2),
      .p1_hurtbox_y1(p1_hurtbox_y1), .p1_hurtbox_y2(p1_hurtbox_y2),
      .p1_hitbox_active(p1_hitbox_active), .p1_hurtbox_active(p1_hurtbox_active),
      .p2_hitbox_x1(p2_hitbox_x1), .p2_hitbox_x2(p2_hitbox_x2),
      .p2_hitbox_y1(p2_hitbox_y1), .p2_hitbox_y2(p2_hitbox_y2),
      .p2_hurtbox_x1(p2_hurtbox_x1), .p2_hurtbox_x2(p2_hurtbox_x2),
      .p2_hurtbox_y1(p2_hurtbox_y1), .p2_hurtbox_y2(p2_hurtbox_y2),
      .p2_hitbox_active(p2_hitbox_active), .p2_hurtbox_active(p2_hurtbox_active),
      .p1_hit(p1_hit), .p2_hit(p2_hit), .clash(clash), .freeze(freeze),
      .p1_score(p1_score), .p2_score(p2_score)
   );

   function automatic bx_t mk(input int x1, input int x2, input int y1, input int y2);
      bx_t b;
      b.x1 = x1; b.x2 = x2; b.y1 = y1; b.y2 = y2;
      return b;
   endfunction

   function automatic bit ovl(input bx_t a, input bx_t b);
      return (a.x1 < b.x2) && (b.x1 < a.x2) && (a.y1 < b.y2) && (b.y1 < a.y2);
   endfunction

   function automatic bx_t rbox(input int base);
      int x1, y1;
      x1 = base + int'($urandom_range(0, 50));
      y1 = base + int'($urandom_range(0, 50));
      return mk(x1, x1 + int'($urandom_range(0, 12)), y1, y1 + int'($urandom_range(0, 12)));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(input bx_t a1, input bx_t h1, input bx_t a2, input bx_t h2,
                        input logic [3:0] act);
      p1_hitbox_x1  = 10'(a1.x1); p1_hitbox_x2  = 10'(a1.x2);
      p1_hitbox_y1  = 10'(a1.y1); p1_hitbox_y2  = 10'(a1.y2);
      p1_hurtbox_x1 = 10'(h1.x1); p1_hurtbox_x2 = 10'(h1.x2);
      p1_hurtbox_y1 = 10'(h1.y1); p1_hurtbox_y2 = 10'(h1.y2);
      p2_hitbox_x1  = 10'(a2.x1); p2_hitbox_x2  = 10'(a2.x2);
      p2_hitbox_y1  = 10'(a2.y1); p2_hitbox_y2  = 10'(a2.y2);
      p2_hurtbox_x1 = 10'(h2.x1); p2_hurtbox_x2 = 10'(h2.x2);
      p2_hurtbox_y1 = 10'(h2.y1); p2_hurtbox_y2 = 10'(h2.y2);
      {p1_hitbox_active, p1_hurtbox_active, p2_hitbox_active, p2_hurtbox_active} = act;
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; frame_tick = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_c1 = 0; m_c2 = 0; m_frz = 0; m_s1 = 0; m_s2 = 0;
   endtask

   // Reference frame rules; updates the model and the expected pulses.
   task automatic model_tick(input bx_t a1, input bx_t h1, input bx_t a2, input bx_t h2,
                             input logic [3:0] act);
      bit r1, r2;
      e_p1 = 0; e_p2 = 0; e_cl = 0;
      if (m_frz > 0) begin
         m_frz--;
         return;
      end
      if (!act[3]) m_c1 = 0;
      if (!act[1]) m_c2 = 0;
      r1 = act[3] && act[0] && ovl(a1, h2) && !m_c1;
      r2 = act[1] && act[2] && ovl(a2, h1) && !m_c2;
      if (r1) m_c1 = 1;
      if (r2) m_c2 = 1;
`ifdef HIT_CLASH_EN
      if (r1 && r2) e_cl = 1;
      else begin e_p1 = int'(r1); e_p2 = int'(r2); end
`else
      e_p1 = int'(r1); e_p2 = int'(r2);
`endif
      if (e_p1 == 1 && m_s1 < SMAX) m_s1++;
      if (e_p2 == 1 && m_s2 < SMAX) m_s2++;
      if (r1 || r2) m_frz = HS;
   endtask

   task automatic chk_all(input string tag);
      chk({tag, " p1_hit"}, p1_hit, e_p1);
      chk({tag, " p2_hit"}, p2_hit, e_p2);
      chk({tag, " clash"}, clash, e_cl);
      chk({tag, " freeze"}, freeze, m_frz > 0);
      chk({tag, " p1_score"}, p1_score, m_s1);
      chk({tag, " p2_score"}, p2_score, m_s2);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[9];
      bx_t z, ov_a, ov_h, a1, h1, a2, h2;
      logic [3:0] act;
      int cnt;

      z = mk(0, 0, 0, 0);
      ov_a = mk(100, 130, 34, 94);
      ov_h = mk(120, 160, 0, 128);
      vt[0] = '{ov_a, z, z, ov_h, 4'b1001, 1, 0, 0};
      vt[1] = '{mk(90, 120, 34, 94), z, z, ov_h, 4'b1001, 0, 0, 0};
      vt[2] = '{mk(100, 130, 0, 50), z, z, mk(120, 160, 50, 100), 4'b1001, 0, 0, 0};
      vt[3] = '{ov_a, z, z, ov_h, 4'b1000, 0, 0, 0};
      vt[4] = '{ov_a, z, z, ov_h, 4'b0001, 0, 0, 0};
      vt[5] = '{z, mk(230, 300, 30, 90), mk(200, 240, 10, 40), z, 4'b0110, 0, 1, 0};
`ifdef HIT_CLASH_EN
      vt[6] = '{ov_a, mk(230, 300, 30, 90), mk(200, 240, 10, 40), ov_h, 4'b1111, 0, 0, 1};
`else
      vt[6] = '{ov_a, mk(230, 300, 30, 90), mk(200, 240, 10, 40), ov_h, 4'b1111, 1, 1, 0};
`endif
      vt[7] = '{mk(90, 121, 34, 94), z, z, ov_h, 4'b1001, 1, 0, 0};
      vt[8] = '{mk(1000, 1023, 1000, 1023), z, z, mk(1022, 1023, 1022, 1023), 4'b1001, 1, 0, 0};

      drive(z, z, z, z, 4'b0000);
      do_reset();
      chk("reset p1_hit", p1_hit, 0);
      chk("reset p2_hit", p2_hit, 0);
      chk("reset clash", clash, 0);
      chk("reset freeze", freeze, 0);
      chk("reset p1_score", p1_score, 0);
      chk("reset p2_score", p2_score, 0);

      // vector table: one frame from reset
      for (int i = 0; i < 9; i++) begin
         do_reset();
         drive(vt[i].a1, vt[i].h1, vt[i].a2, vt[i].h2, vt[i].act);
         tick();
         chk($sformatf("vec%0d p1_hit", i), p1_hit, vt[i].ep1);
         chk($sformatf("vec%0d p2_hit", i), p2_hit, vt[i].ep2);
         chk($sformatf("vec%0d clash", i), clash, vt[i].ecl);
         chk($sformatf("vec%0d freeze", i), freeze, (vt[i].ep1 | vt[i].ep2 | vt[i].ecl) != 0);
         chk($sformatf("vec%0d p1_score", i), p1_score, vt[i].ep1);
         chk($sformatf("vec%0d p2_score", i), p2_score, vt[i].ep2);
      end

      // single hit: pulse width and freeze length
      do_reset();
      drive(ov_a, z, z, ov_h, 4'b1001);
      tick();
      chk("single p1_hit", p1_hit, 1);
      @(posedge clk); #1;
      chk("single pulse width", p1_hit, 0);
      chk("single freeze held", freeze, 1);
      for (int k = 1; k <= HS; k++) begin
         tick();
         chk($sformatf("freeze after tick %0d", k), freeze, k < HS);
         chk("no hit during freeze", p1_hit, 0);
      end
      chk("single p1_score", p1_score, 1);

      // once per window, then re-arm
      do_reset();
      drive(ov_a, z, z, ov_h, 4'b1001);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         cnt += int'(p1_hit);
      end
      chk("window hit count", cnt, 1);
      chk("window p1_score", p1_score, 1);
      chk("window freeze done", freeze, 0);
      drive(ov_a, z, z, ov_h, 4'b0001);
      tick();
      chk("window release no hit", p1_hit, 0);
      drive(ov_a, z, z, ov_h, 4'b1001);
      tick();
      chk("window rearm p1_hit", p1_hit, 1);
      chk("window rearm p1_score", p1_score, 2);

      // saturation over 17 windows, then holding
      do_reset();
      cnt = 0;
      for (int w = 0; w < 18; w++) begin
         drive(ov_a, z, z, ov_h, 4'b1001);
         tick();
         cnt += int'(p1_hit);
         repeat (HS) tick();
         drive(ov_a, z, z, ov_h, 4'b0001);
         tick();
         if (w == 16) chk("sat p1_score after 17", p1_score, SMAX);
      end
      chk("sat pulse count", cnt, 18);
      chk("sat p1_score hold", p1_score, SMAX);
      chk("sat p2_score", p2_score, 0);

      // reset in the middle of hitstop
      do_reset();
      drive(ov_a, z, z, ov_h, 4'b1001);
      tick();
      repeat (3) tick();
      chk("midhs freeze before rst", freeze, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midhs freeze", freeze, 0);
      chk("midhs p1_score", p1_score, 0);
      tick();
      chk("midhs rehit p1_hit", p1_hit, 1);
      chk("midhs rehit p1_score", p1_score, 1);
      chk("midhs rehit freeze", freeze, 1);

      // randomized frames against the model; junk between ticks must be ignored
      do_reset();
      for (int n = 0; n < 600; n++) begin
         int base;
         if ($urandom_range(0, 99) == 0) begin
            do_reset();
            chk("rand reset p1_score", p1_score, 0);
            chk("rand reset freeze", freeze, 0);
         end
         base = ($urandom_range(0, 3) == 0) ? 960 : 0;
         a1 = rbox(base); h1 = rbox(base); a2 = rbox(base); h2 = rbox(base);
         act = {$urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 5) != 0};
         drive(a1, h1, a2, h2, act);
         tick();
         model_tick(a1, h1, a2, h2, act);
         chk_all($sformatf("rand%0d", n));
         if ($urandom_range(0, 1) == 1) begin
            drive(rbox(base), rbox(base), rbox(base), rbox(base), 4'($urandom));
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
            e_p1 = 0; e_p2 = 0; e_cl = 0;
            chk_all($sformatf("rand%0d idle", n));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
